spi_controller: RTL
===================

Name: spi_controller

Overview:
SPI controller (initiator) that drives the write-only SPI register peripheral feeding the PWM block. It converts a parallel register-write request into one 16-bit Mode-0 frame on sclk/copi/ncs. It is used on-chip for loopback self-test and as the bench/FPGA-side driver that programs the output-enable, PWM-enable and duty-cycle registers.

Parameters:
CLK_DIV, 4, clk cycles per sclk half-period; legal range >= 1. Must be >= 4 when the peripheral samples through a 3-flop synchroniser on the same clk.
FRAME_BITS, 16, bits per frame; fixed as 1 R/W bit + 7 address bits + 8 data bits.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
start  input  1  request a frame; sampled only when busy=0
rw  input  1  frame bit 15; 1 = write. The value is passed through unchanged.
addr  input  7  register address, frame bits 14:8
wdata  input  8  register data, frame bits 7:0
busy  output  1  frame in progress
done  output  1  one-cycle pulse at frame completion
sclk  output  1  SPI clock, idles low
copi  output  1  serial data, MSB first
ncs  output  1  chip select, active low

Behaviour:
- All outputs are registered.
- Reset values: sclk=0, copi=0, ncs=1, busy=0, done=0, state=IDLE, shift register=0, divider and bit counters=0.
- Reset asserted mid-frame: outputs return to their reset values immediately and the frame is abandoned. No done pulse is produced.
- Accept: on the rising clk edge where state=IDLE and start=1, latch shreg={rw,addr,wdata}.
  - On that same edge: busy<=1, ncs<=0, copi<=rw, state<=SETUP.
  - start while busy=1 is ignored; no queuing.
- A divider counter counts 0..CLK_DIV-1. A "tick" occurs when it wraps. The counter resets to 0 on every state change.
- SETUP: ncs=0, sclk=0, copi=bit15. Lasts CLK_DIV cycles, then goes to SHIFT_HI with bit counter=0.
- SHIFT_HI: sclk=1 for CLK_DIV cycles. The peripheral samples copi on the sclk rising edge.
- SHIFT_LO: sclk=0 for CLK_DIV cycles.
  - If bit counter < 15: at the start of SHIFT_LO (the falling-edge cycle), shift shreg left and drive copi=next bit; increment the bit counter.
  - If bit counter = 15: copi holds the last bit and the state goes to HOLD after the tick.
- copi changes only while sclk=0. It is stable for CLK_DIV cycles before and after every rising sclk edge.
- HOLD: sclk=0, ncs=0 for CLK_DIV cycles, then ncs<=1 and state goes to GAP.
- GAP: ncs=1, copi=0 for CLK_DIV cycles. Then busy<=0, done<=1 for one cycle, state goes to IDLE.
- Frame length: busy is high for exactly 35*CLK_DIV cycles (1 SETUP + 32 half-periods + 1 HOLD + 1 GAP).
  - ncs is low for exactly 34*CLK_DIV cycles.
  - Exactly 16 rising sclk edges occur per frame.
- The done cycle is an IDLE cycle, so a start present during done is accepted. Back-to-back frames are therefore separated by at least CLK_DIV cycles of ncs=1.
- Bit counter is 4 bits; divider width is $clog2(CLK_DIV) with a minimum of 1. No overflow is possible within a frame.

Test Plan:
- Single write (CLK_DIV=4): rst pulse, then start with rw=1, addr=0x04, wdata=0x80 → copi sampled on the 16 sclk rising edges = 1,0000100,10000000. ncs low for 136 cycles, busy high for 140 cycles, single done pulse, sclk low whenever ncs=1.
- Loopback: controller drives the SPI peripheral (CLK_DIV=4, same clk). Write addr 0x00=0xFF, 0x02=0x01, 0x04=0x80 → peripheral reg_0=0xFF, reg_2=0x01, reg_4=0x80; pwm output bit 0 toggles at 50% duty.
- Back-to-back: start held high across two frames with different addr/wdata → two complete frames, each with 16 rising edges. ncs high for ≥CLK_DIV cycles between them; two done pulses.
- Start while busy: pulse start with wdata=0xAA mid-frame → frame content unchanged, no extra frame, one done pulse.
- Reset mid-frame: assert rst after the 7th rising sclk edge → ncs=1, sclk=0, copi=0, busy=0 immediately, no done. A new start after release produces a full correct frame.
- CLK_DIV=1: write addr 0x01, wdata=0x5A → busy exactly 35 cycles, sclk toggles every cycle, correct 16-bit frame.

Source files
------------

// File: rtl/spi_controller_if.sv
// Request/status and SPI pin bundle for spi_controller.
// master = requester side, slave = the controller itself.
interface spi_controller_if;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic       sclk;
  logic       copi;
  logic       ncs;

  modport master (output start, rw, addr, wdata, input busy, done, sclk, copi, ncs);
  modport slave  (input start, rw, addr, wdata, output busy, done, sclk, copi, ncs);
endinterface

// File: rtl/spi_controller.sv
// SPI Mode-0 initiator: one 16-bit {rw,addr,wdata} frame per accepted start,
// MSB first, with setup/hold/gap phases of CLK_DIV cycles each.
module spi_controller #(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 16
) (
  input  logic clk,
  input  logic rst,
  spi_controller_if.slave bus
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP} state_e;

  state_e                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [3:0]              bit_q, bit_d;
  logic                    last_q, last_d;
  // Bit 15 goes straight to copi on accept, so only the remaining bits are kept.
  logic [FRAME_BITS-2:0]   shreg_q, shreg_d;
  logic                    sclk_q, sclk_d, copi_q, copi_d, ncs_q, ncs_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic                    tick;

  assign tick = (div_q == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      last_q  <= 1'b0;
      shreg_q <= '0;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      ncs_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      last_q  <= last_d;
      shreg_q <= shreg_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      ncs_q   <= ncs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + 1'b1;
    bit_d   = bit_q;
    last_d  = last_q;
    shreg_d = shreg_q;
    sclk_d  = sclk_q;
    copi_d  = copi_q;
    ncs_d   = ncs_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        div_d = '0;
        if (bus.start) begin
          shreg_d = {bus.addr, bus.wdata};
          copi_d  = bus.rw;
          ncs_d   = 1'b0;
          busy_d  = 1'b1;
          bit_d   = '0;
          last_d  = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: if (tick) begin
        sclk_d  = 1'b1;
        bit_d   = '0;
        state_d = SHIFT_HI;
      end
      SHIFT_HI: if (tick) begin
        sclk_d  = 1'b0;
        state_d = SHIFT_LO;
        // The falling edge is where the next bit is launched.
        if (bit_q < 4'(FRAME_BITS - 1)) begin
          copi_d  = shreg_q[FRAME_BITS-2];
          shreg_d = {shreg_q[FRAME_BITS-3:0], 1'b0};
          bit_d   = bit_q + 1'b1;
        end else begin
          last_d  = 1'b1;
        end
      end
      SHIFT_LO: if (tick) begin
        if (last_q) begin
          state_d = HOLD;
        end else begin
          sclk_d  = 1'b1;
          state_d = SHIFT_HI;
        end
      end
      HOLD: if (tick) begin
        ncs_d   = 1'b1;
        copi_d  = 1'b0;
        state_d = GAP;
      end
      GAP: if (tick) begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.sclk = sclk_q;
  assign bus.copi = copi_q;
  assign bus.ncs  = ncs_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule
